axi_line_master: RTL

AXI4 burst master that moves whole cache lines between the CPU cache controllers and the AXI memory side. It accepts one line request at a time, either a refill read or a dirty-line writeback, and runs it as a single INCR burst. The requester side is a simple valid/ready handshake. It is the initiator counterpart of the simulation AXI RAM and of the SoC AXI crossbar slave port.

---
 rtl/axi_pkg.sv | 15 +
 rtl/axi_line_master.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI4 encodings and the line-master state type
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} line_state_e;

endpackage

// File: rtl/axi_line_master.sv
// rtl/axi_line_master.sv - AXI4 master moving one cache line per INCR burst
module axi_line_master
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0,
  parameter int LINE_WORDS = 8
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wline,
  output logic                             rd_valid,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_last,
  output logic                             done,
  output logic                             err,
  output logic [ID_WIDTH-1:0]              m_axi_awid,
  output logic [ADDR_WIDTH-1:0]            m_axi_awaddr,
  output logic [7:0]                       m_axi_awlen,
  output logic [2:0]                       m_axi_awsize,
  output logic [1:0]                       m_axi_awburst,
  output logic                             m_axi_awlock,
  output logic [3:0]                       m_axi_awcache,
  output logic [2:0]                       m_axi_awprot,
  output logic                             m_axi_awvalid,
  input  logic                             m_axi_awready,
  output logic [DATA_WIDTH-1:0]            m_axi_wdata,
  output logic [STRB_WIDTH-1:0]            m_axi_wstrb,
  output logic                             m_axi_wlast,
  output logic                             m_axi_wvalid,
  input  logic                             m_axi_wready,
  input  logic [ID_WIDTH-1:0]              m_axi_bid,
  input  logic [1:0]                       m_axi_bresp,
  input  logic                             m_axi_bvalid,
  output logic                             m_axi_bready,
  output logic [ID_WIDTH-1:0]              m_axi_arid,
  output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
  output logic [7:0]                       m_axi_arlen,
  output logic [2:0]                       m_axi_arsize,
  output logic [1:0]                       m_axi_arburst,
  output logic                             m_axi_arlock,
  output logic [3:0]                       m_axi_arcache,
  output logic [2:0]                       m_axi_arprot,
  output logic                             m_axi_arvalid,
  input  logic                             m_axi_arready,
  input  logic [ID_WIDTH-1:0]              m_axi_rid,
  input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
  input  logic [1:0]                       m_axi_rresp,
  input  logic                             m_axi_rlast,
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready
);

  localparam int IW  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int CW  = IW + 1;
  localparam int OFF = $clog2(LINE_WORDS * STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((64'd1 << OFF) - 64'd1);
  localparam logic [CW-1:0]         LAST_BEAT  = CW'(LINE_WORDS - 1);

  line_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] words_q [LINE_WORDS];
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  acc_q, acc_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  live_q;
  logic                  accept;
  logic                  beat_err;
  logic                  unused_ids;

  // live_q holds req_ready low until the first edge after reset release
  assign req_ready  = live_q && (state_q == IDLE);
  assign accept     = req_valid && req_ready;
  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  // rlast must coincide exactly with the final counted beat
  assign beat_err = (m_axi_rresp != RESP_OKAY) || (m_axi_rlast != (cnt_q == LAST_BEAT));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = req_write ? AW : AR;
        cnt_d   = '0;
        acc_d   = 1'b0;
      end
      AR: if (m_axi_arready) state_d = R;
      R: if (m_axi_rvalid) begin
        cnt_d = cnt_q + CW'(1);
        if (m_axi_rlast) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = acc_q | beat_err;
        end else begin
          acc_d = acc_q | beat_err;
        end
      end
      AW: if (m_axi_awready) state_d = W;
      W: if (m_axi_wready) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BEAT) state_d = B;
      end
      B: if (m_axi_bvalid) begin
        state_d = IDLE;
        done_d  = 1'b1;
        err_d   = (m_axi_bresp != RESP_OKAY);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
      addr_q  <= '0;
      for (int i = 0; i < LINE_WORDS; i++) words_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
      if (accept) begin
        addr_q <= req_addr & ALIGN_MASK;
        if (req_write) begin
          for (int i = 0; i < LINE_WORDS; i++) words_q[i] <= req_wline[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign done = done_q;
  assign err  = err_q;

  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'(LINE_WORDS - 1);
  assign m_axi_awsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awvalid = (state_q == AW);

  assign m_axi_wvalid  = (state_q == W);
  assign m_axi_wdata   = words_q[cnt_q[IW-1:0]];
  assign m_axi_wstrb   = m_axi_wvalid ? '1 : '0;
  assign m_axi_wlast   = m_axi_wvalid && (cnt_q == LAST_BEAT);
  assign m_axi_bready  = (state_q == B);

  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(LINE_WORDS - 1);
  assign m_axi_arsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arvalid = (state_q == AR);
  assign m_axi_rready  = (state_q == R);

  // refill beats bypass any register so the requester sees them in the R cycle
  assign rd_valid = m_axi_rready && m_axi_rvalid;
  assign rd_data  = m_axi_rready ? m_axi_rdata : '0;
  assign rd_last  = rd_valid && m_axi_rlast;

endmodule
